branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameters: name, default, meaning.
- XLEN, from mmm_pkg, datapath width.
- DEPTH, 4, prediction queue entries; power of two, >= 2.
REQ-002 Ports: name  direction  width  meaning.
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous pipeline flush.
- pred_valid_i  in  1  fetch presents a predicted branch.
- pred_ready_o  out  1  queue accepts a prediction this cycle.
- pred_pc_i  in  XLEN  branch PC.
- pred_taken_i  in  1  predicted direction.
- pred_target_i  in  XLEN  predicted target.
- exe_valid_i  in  1  execute stage reports the oldest branch outcome.
- exe_taken_i  in  1  actual direction.
- exe_target_i  in  XLEN  actual taken target.
- res_o  out  resolution_t  resolution to the predictor: valid, taken, pc.
- mispredict_o  out  1  one-cycle mispredict pulse.
- redirect_pc_o  out  XLEN  correct fetch PC, valid when mispredict_o=1.
- err_o  out  1  one-cycle pulse: outcome arrived with an empty queue.

Function
REQ-003 Prediction queue: in-order FIFO of DEPTH entries {pc, taken, target}, with read pointer, write pointer and occupancy count (0..DEPTH).
REQ-004 Push: occurs when pred_valid_i && pred_ready_o.
REQ-005 pred_ready_o = (state==RUN) && (count<DEPTH) && !flush_i; combinational, no dependence on a same-cycle pop.
REQ-006 Pop: occurs when exe_valid_i && count>0 && state==RUN; outcomes are strictly in program order.
REQ-007 Empty queue: exe_valid_i with count==0 pops nothing and produces no resolution; err_o=1 next cycle. A same-cycle push does not bypass.
REQ-008 Latency: res_o, mispredict_o, redirect_pc_o and err_o are registered; valid exactly one cycle after the pop.
REQ-009 res_o fields on a pop:
- res_o.valid=1
- res_o.pc = head pc
- res_o.taken = exe_taken_i
REQ-010 res_o.valid=0 in every cycle that follows a non-pop cycle.
REQ-011 Mispredict condition: (head taken != exe_taken_i) or (exe_taken_i && head target != exe_target_i).
REQ-012 Redirect value:
- exe_taken_i=1: redirect_pc_o = exe_target_i.
- exe_taken_i=0: redirect_pc_o = head pc + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0 for XLEN=32).
REQ-013 Queue on mispredict: all younger entries are discarded (count=0, pointers equal) at the next edge; a push in the same cycle is dropped.
REQ-014 FSM states RUN and RECOVER:
- Reset: RUN.
- RUN -> RECOVER on a mispredicting pop.
- RECOVER -> RUN unconditionally after one cycle.
REQ-015 RECOVER behaviour: pred_ready_o=0, exe_valid_i ignored, err_o not raised.
REQ-016 Pointer wrap: pointers wrap modulo DEPTH. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
REQ-017 flush_i: highest priority. At the next edge it empties the queue, forces RUN and zeroes all registered outputs. A push or pop in the flush cycle has no effect.

Reset
REQ-018 While rst_n_i=0, asynchronously:
- count=0, pointers=0, state=RUN
- res_o all-zero
- mispredict_o=0, redirect_pc_o=0, err_o=0
- queue storage need not be cleared.
REQ-019 pred_ready_o=0 while rst_n_i=0. Reset asserted mid-operation discards all in-flight entries.

Verification
REQ-020 Correct prediction: push {pc=0x100, taken=1, target=0x200}, then exe {taken=1, target=0x200}. Next cycle: res_o={valid=1, taken=1, pc=0x100}, mispredict_o=0, count=0.
REQ-021 Direction mispredict with younger entries:
- Push 0x100 (not-taken), 0x104, 0x108.
- Exe {taken=1, target=0x300}.
- Next cycle: mispredict_o=1, redirect_pc_o=0x300, res_o.pc=0x100, count=0, pred_ready_o=0 for one cycle, then 1.
REQ-022 Target mispredict: predicted {taken=1, target=0x200}, actual {taken=1, target=0x240} -> mispredict_o=1, redirect_pc_o=0x240.
REQ-023 Full queue and wrap:
- Push DEPTH entries -> pred_ready_o=0.
- Pop one while pred_valid_i=1 -> pred_ready_o stays 0 that cycle, then 1.
- 3*DEPTH further push/pop pairs -> resolutions emerge in push order.
REQ-024 Error and flush:
- exe_valid_i on an empty queue -> err_o=1 for one cycle, res_o.valid=0.
- flush_i with 3 entries queued and a simultaneous exe -> no resolution emitted, count=0 next cycle.
REQ-025 Reset mid-operation: rst_n_i low with 2 entries queued and mispredict_o=1 -> all outputs 0 immediately; after release, state=RUN and pred_ready_o=1.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: keeps fetch-stage predictions in program order and
// compares each against the execute-stage outcome. It reports the
// resolution to the predictor and, on a mispredict, the corrected fetch PC.

package mmm_pkg;
  parameter int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pc;
  } resolution_t;
endpackage

module branch_resolver
  import mmm_pkg::*;
#(
  parameter int XLEN  = mmm_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            pred_valid_i,
  output logic            pred_ready_o,
  input  logic [XLEN-1:0] pred_pc_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            exe_valid_i,
  input  logic            exe_taken_i,
  input  logic [XLEN-1:0] exe_target_i,
  output resolution_t     res_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_e;

  // prediction storage; contents are don't-care until written
  logic [DEPTH-1:0][XLEN-1:0] pc_mem;
  logic [DEPTH-1:0][XLEN-1:0] tgt_mem;
  logic [DEPTH-1:0]           tk_mem;

  state_e          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  resolution_t     res_q, res_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            err_q, err_d;

  logic            run, push, pop, mis;
  logic [XLEN-1:0] head_pc, head_tgt;
  logic            head_tk;

  assign run      = (state_q == RUN);
  assign head_pc  = pc_mem[rd_ptr_q];
  assign head_tgt = tgt_mem[rd_ptr_q];
  assign head_tk  = tk_mem[rd_ptr_q];

  // ready never looks at a same-cycle pop; gated low while in reset
  assign pred_ready_o = rst_n_i && run && (count_q < CW'(DEPTH)) && !flush_i;
  assign push = pred_valid_i && pred_ready_o;
  // flush wins over a pop in the same cycle
  assign pop  = exe_valid_i && run && (count_q != '0) && !flush_i;
  assign mis  = pop && ((head_tk != exe_taken_i) ||
                        (exe_taken_i && (head_tgt != exe_target_i)));

  // next-state for queue bookkeeping, FSM and registered outputs
  always_comb begin
    state_d  = RUN;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    res_d    = '0;
    mis_d    = 1'b0;
    redir_d  = '0;
    err_d    = 1'b0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        res_d.valid = 1'b1;
        res_d.taken = exe_taken_i;
        res_d.pc    = head_pc;
      end
      err_d = exe_valid_i && run && (count_q == '0);
      if (mis) begin
        // younger entries are wrong-path; a same-cycle push is dropped too
        state_d  = RECOVER;
        mis_d    = 1'b1;
        redir_d  = exe_taken_i ? exe_target_i : head_pc + XLEN'(4);
        rd_ptr_d = wr_ptr_q;
        count_d  = '0;
      end else begin
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // control state and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      res_q    <= '0;
      mis_q    <= 1'b0;
      redir_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      res_q    <= res_d;
      mis_q    <= mis_d;
      redir_q  <= redir_d;
      err_q    <= err_d;
    end
  end

  // storage write; a dropped push may land here but the pointer does not advance
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= pred_pc_i;
      tgt_mem[wr_ptr_q] <= pred_target_i;
      tk_mem[wr_ptr_q]  <= pred_taken_i;
    end
  end

  assign res_o         = res_q;
  assign mispredict_o  = mis_q;
  assign redirect_pc_o = redir_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the resolver.

module tb_branch_resolver;
  import mmm_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        pred_valid_i = 1'b0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_pc_i = '0;
  logic [31:0] pred_target_i = '0;
  logic        exe_valid_i = 1'b0;
  logic        exe_taken_i = 1'b0;
  logic [31:0] exe_target_i = '0;
  logic        pred_ready_o;
  resolution_t res_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        err_o;

  branch_resolver #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
    .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i),
    .exe_valid_i(exe_valid_i), .exe_taken_i(exe_taken_i),
    .exe_target_i(exe_target_i),
    .res_o(res_o), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference model: outstanding predictions in program order + recovery flag
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } ent_t;
  ent_t q[$];
  bit   rec = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // one clock cycle; entered and left 1 time unit after a rising edge
  task automatic cyc(input logic pv, input logic [31:0] ppc, input logic ptk,
                     input logic [31:0] ptg, input logic ev, input logic etk,
                     input logic [31:0] etg, input logic fl);
    bit          rdy, push, pop, mis, err;
    ent_t        h;
    logic [31:0] rpc;
    pred_valid_i = pv; pred_pc_i = ppc; pred_taken_i = ptk; pred_target_i = ptg;
    exe_valid_i = ev; exe_taken_i = etk; exe_target_i = etg; flush_i = fl;
    #3;
    rdy = !rec && (q.size() < DEPTH) && !fl;
    chk("ready", {31'b0, pred_ready_o}, {31'b0, rdy});
    push = pv && rdy;
    pop  = ev && !rec && !fl && (q.size() > 0);
    err  = ev && !rec && !fl && (q.size() == 0);
    mis  = 1'b0;
    rpc  = '0;
    h    = '{pc: '0, tk: 1'b0, tg: '0};
    if (fl) begin
      q.delete();
      rec = 1'b0;
    end else begin
      if (pop) begin
        h   = q.pop_front();
        mis = (h.tk != etk) || (etk && (h.tg != etg));
        rpc = etk ? etg : h.pc + 32'd4;
      end
      rec = mis;
      if (mis) q.delete();
      else if (push) q.push_back('{pc: ppc, tk: ptk, tg: ptg});
    end
    @(posedge clk_i); #1;
    chk("res_valid", {31'b0, res_o.valid}, {31'b0, pop});
    if (pop) begin
      chk("res_pc", res_o.pc, h.pc);
      chk("res_taken", {31'b0, res_o.taken}, {31'b0, etk});
    end
    chk("mispredict", {31'b0, mispredict_o}, {31'b0, mis});
    if (mis) chk("redirect", redirect_pc_o, rpc);
    if (fl)  chk("flush_redirect", redirect_pc_o, 32'h0);
    chk("err", {31'b0, err_o}, {31'b0, err});
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    cyc(1'b1, pc, tk, tg, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic exe(input logic tk, input logic [31:0] tg);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, tk, tg, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'b0, pred_ready_o}, 32'h0);
    chk({tag, "_res"}, {31'b0, res_o.valid | res_o.taken | (|res_o.pc)}, 32'h0);
    chk({tag, "_mis"}, {31'b0, mispredict_o}, 32'h0);
    chk({tag, "_redir"}, redirect_pc_o, 32'h0);
    chk({tag, "_err"}, {31'b0, err_o}, 32'h0);
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("reset");
    q.delete();
    rec = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    pred_valid_i = 1'b0;
    #1;
    chk_all_zero("por");
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle();

    // correct prediction
    push(32'h100, 1'b1, 32'h200);
    exe(1'b1, 32'h200);
    idle();

    // direction mispredict with younger entries, then recovery cycle
    push(32'h100, 1'b0, 32'h104);
    push(32'h104, 1'b0, 32'h108);
    push(32'h108, 1'b1, 32'h400);
    exe(1'b1, 32'h300);
    idle();
    idle();
    exe(1'b0, 32'h0);  // queue discarded: error

    // target mispredict
    push(32'h180, 1'b1, 32'h200);
    exe(1'b1, 32'h240);
    idle();

    // not-taken redirect wraps at top of address space
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    exe(1'b0, 32'h0);
    idle();

    // fill, pop while presenting, then wrap traffic
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    cyc(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++)
      cyc(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    while (q.size() > 0) exe(1'b0, 32'h0);

    // error on empty queue; same-cycle push does not bypass
    cyc(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    exe(1'b0, 32'h0);

    // flush with 3 entries and a simultaneous exe
    push(32'h600, 1'b0, 32'h0);
    push(32'h604, 1'b0, 32'h0);
    push(32'h608, 1'b0, 32'h0);
    cyc(1'b1, 32'h60C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    exe(1'b0, 32'h0);

    // reset mid-operation with entries queued
    push(32'h700, 1'b0, 32'h0);
    push(32'h704, 1'b0, 32'h0);
    apply_reset();
    idle();
    exe(1'b0, 32'h0);

    // reset while mispredict_o is high
    push(32'h800, 1'b1, 32'h200);
    exe(1'b0, 32'h0);
    apply_reset();
    idle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ppc;
      ppc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cyc(($urandom_range(0, 3) != 0), ppc, 1'($urandom()),
          ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h240,
          ($urandom_range(0, 1) != 0), 1'($urandom()),
          ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h240,
          ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
